// File: rtl/tx_arbiter.sv
// tx_arbiter: two private byte FIFOs drained round-robin into the tx_pipe
// push interface. Pushes are spaced IDLE -> ISSUE -> GAP so the pipe's full
// flag always has a settled cycle before the next decision is made.
//
// Handshake: a source byte is taken on every clk edge where srcN_push=1 and
// its FIFO is not full (srcN_full reflects the registered count); otherwise
// it is dropped and ovf[N] latches. Downstream, tx_push_back is a one-cycle
// strobe with tx_data_in valid in that cycle; it is only raised when tx_full
// was low in the preceding IDLE cycle, so no byte is ever refused downstream.
module tx_arbiter #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         src0_push,
   input  logic [W-1:0] src0_data,
   output logic         src0_full,
   input  logic         src1_push,
   input  logic [W-1:0] src1_data,
   output logic         src1_full,
   input  logic         tx_full,
   output logic         tx_push_back,
   output logic [W-1:0] tx_data_in,
   output logic         grant,
   output logic [1:0]   ovf,
   output logic         busy,
   output logic [1:0]   fsm_state
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t         state;
   logic [W-1:0]   mem   [2][DEPTH];
   logic [AW-1:0]  wp    [2];
   logic [AW-1:0]  rp    [2];
   logic [CW-1:0]  cnt   [2];
   logic [W-1:0]   wdata [2];
   logic [1:0]     push_req;
   logic [1:0]     wr_ok;
   logic [1:0]     nonempty;
   logic [1:0]     pop;
   logic           issue;
   logic           sel;

   // Write acceptance, scheduling decision and pop selection for this cycle.
   always_comb begin
      push_req = {src1_push, src0_push};
      wdata[0] = src0_data;
      wdata[1] = src1_data;
      for (int i = 0; i < 2; i++) begin
         nonempty[i] = (cnt[i] != '0);
         // Acceptance looks only at the registered count: a pop in the same
         // cycle does not make room for a push into a full FIFO.
         wr_ok[i]    = push_req[i] && (cnt[i] != CW'(DEPTH));
      end
      issue = (state == IDLE) && !tx_full && (nonempty != 2'b00);
      // With both sources waiting, alternate away from the last winner;
      // otherwise take whichever one has data.
      sel   = (nonempty == 2'b11) ? ~grant : nonempty[1];
      pop   = 2'b00;
      if (issue) begin
         pop = sel ? 2'b10 : 2'b01;
      end
   end

   // FIFO storage writes; contents need no reset because count gates reads.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (wr_ok[i]) begin
            mem[i][wp[i]] <= wdata[i];
         end
      end
   end

   // FIFO pointers, occupancy counts and sticky overflow flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            wp[i]  <= '0;
            rp[i]  <= '0;
            cnt[i] <= '0;
         end
         ovf <= 2'b00;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (wr_ok[i]) begin
               wp[i] <= wp[i] + AW'(1);
            end
            if (pop[i]) begin
               rp[i] <= rp[i] + AW'(1);
            end
            if (push_req[i] && !wr_ok[i]) begin
               ovf[i] <= 1'b1;
            end
            case ({wr_ok[i], pop[i]})
               2'b10:   cnt[i] <= cnt[i] + CW'(1);
               2'b01:   cnt[i] <= cnt[i] - CW'(1);
               default: cnt[i] <= cnt[i];
            endcase
         end
      end
   end

   // Scheduler FSM with registered push strobe, data and grant.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         tx_push_back <= 1'b0;
         tx_data_in   <= '0;
         grant        <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (issue) begin
                  state        <= ISSUE;
                  tx_push_back <= 1'b1;
                  grant        <= sel;
                  tx_data_in   <= mem[sel][rp[sel]];
               end
            end
            ISSUE: begin
               // tx_full is not consulted here: the push has already happened.
               state        <= GAP;
               tx_push_back <= 1'b0;
            end
            GAP: begin
               state <= IDLE;
            end
            default: begin
               state        <= IDLE;
               tx_push_back <= 1'b0;
            end
         endcase
      end
   end

   assign src0_full = (cnt[0] == CW'(DEPTH));
   assign src1_full = (cnt[1] == CW'(DEPTH));
   assign busy      = nonempty[0] || nonempty[1] || (state != IDLE);
   assign fsm_state = state;

endmodule
